// File: rtl/gate_lab_pkg.sv
// Shared types for the gate demonstrator: gate mode codes, heartbeat width, gate evaluation.
// Pure declarations; no latency and no backpressure of its own.
package gate_lab_pkg;

  typedef enum logic [2:0] {
    MODE_NAND = 3'd0,
    MODE_NOR  = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5
  } gate_mode_t;

  localparam logic [2:0] MODE_LAST = 3'd5;
  localparam int         HB_BITS   = 24;

  // Codes 6/7 are never produced by the FSM but fall back to NAND if seen.
  function automatic logic gate_eval(input gate_mode_t m, input logic and_r,
                                     input logic or_r, input logic xor_r);
    logic r;
    case (m)
      MODE_NOR:  r = ~or_r;
      MODE_AND:  r = and_r;
      MODE_OR:   r = or_r;
      MODE_XOR:  r = xor_r;
      MODE_XNOR: r = ~xor_r;
      default:   r = ~and_r;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button synchroniser + debouncer with a one-cycle press (1->0) pulse.
// Latency 2 + DEBOUNCE_CYCLES clk from pin to db_n; free-running, no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic db_n,
  output logic fall_pulse
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // A change is taken only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      db_n       <= 1'b1;
      cnt        <= '0;
      fall_pulse <= 1'b0;
    end else begin
      sync1      <= raw_n;
      sync2      <= sync1;
      fall_pulse <= 1'b0;
      if (sync2 != db_n) begin
        if (cnt == CNT_LAST) begin
          db_n       <= sync2;
          cnt        <= '0;
          fall_pulse <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gate_lab.sv
// Debounced N_IN-input gate demonstrator on active-low LEDs, mode cycled by a button; GATE_LAB_HEARTBEAT_EN adds a led_n[5] heartbeat.
// Latency pin->led_n 2 + DEBOUNCE_CYCLES + 1 clk; free-running, no backpressure.
module gate_lab
  import gate_lab_pkg::*;
#(
  parameter int N_IN            = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LED_W           = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  btn_n,
  input  logic             mode_btn_n,
  output logic [LED_W-1:0] led_n,
  output logic [2:0]       mode
);

  logic [N_IN-1:0] op_db_n;
  logic [N_IN-1:0] op_fall_unused;
  logic            mode_db_unused;
  logic            mode_press;
  logic [N_IN-1:0] a;
  logic            result_q;
  gate_mode_t      mode_q;
  gate_mode_t      mode_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_op
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_n     (btn_n[i]),
      .db_n      (op_db_n[i]),
      .fall_pulse(op_fall_unused[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_n     (mode_btn_n),
    .db_n      (mode_db_unused),
    .fall_pulse(mode_press)
  );

  assign a = ~op_db_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_NAND;
    else        mode_q <= mode_d;
  end

  // Wrap covers the unreachable codes too, so a corrupted state recovers to NAND.
  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      if (mode_q >= MODE_LAST) mode_d = MODE_NAND;
      else                     mode_d = gate_mode_t'(mode_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= 1'b0;
    else        result_q <= gate_eval(mode_q, &a, |a, ^a);
  end

  assign mode = mode_q;

`ifdef GATE_LAB_HEARTBEAT_EN
  logic [HB_BITS-1:0] hb_cnt;
  logic               hb_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb_led <= 1'b1;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      if (&hb_cnt) hb_led <= ~hb_led;
    end
  end
`endif

  always_comb begin
    led_n      = '1;
    led_n[0]   = ~result_q;
    led_n[3:1] = ~mode_q;
    led_n[4]   = ~(|a);
`ifdef GATE_LAB_HEARTBEAT_EN
    led_n[5]   = hb_led;
`endif
  end

endmodule

// File: doc/gate_lab.md
Name: gate_lab

Overview:
- Next-generation board-level logic-gate demonstrator for the 6-LED, active-low button/LED FPGA board.
- Takes N_IN push-buttons as gate operands and one mode button that cycles through six gate functions.
- Every button is synchronised and debounced.
- The gate result and current mode are driven onto the active-low LEDs.
- Replaces fixed single-function, unclocked gate tops with one clocked, parametrised block.

Parameters:
- N_IN, 2, number of operand buttons (2..4).
- DEBOUNCE_CYCLES, 270000, consecutive stable clk cycles before a button change is accepted (10 ms at 27 MHz); minimum 2.
- LED_W, 6, width of LED bus (≥5).

Ports:
- clk  input  1  system clock (27 MHz on board).
- rst_n  input  1  asynchronous active-low reset; deassertion assumed synchronous to clk externally.
- btn_n  input  N_IN  raw operand buttons, active-low (0 = pressed), asynchronous to clk.
- mode_btn_n  input  1  raw mode button, active-low, asynchronous.
- led_n  output  LED_W  board LEDs, active-low (0 = lit).
- mode  output  3  current gate mode code, for debug/ILA.

Behaviour:
- Reset: all sync flops and debounced states = 1 (released); debounce counters = 0; mode = 0 (NAND); result_q = 0; led_n = all 1s (all LEDs off); mode output = 0.
- Synchronisation: each raw button passes through a 2-flop synchroniser before debounce.
- Debounce, per button, with state db and counter cnt:
  - If synced sample != db: cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 while still differing: db takes the sample and cnt returns to 0.
  - If the sample equals db on any cycle: cnt clears to 0.
  - Net effect: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples. A glitch shorter than that never changes db.
- Operands: a[i] = ~db(btn_n[i]), so pressed = 1.
- Mode FSM, 6 states, codes 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR:
  - Advances by one on the cycle after the mode button's debounced state falls 1→0 (press edge). Release does nothing.
  - 5 wraps to 0.
  - Holding the button gives exactly one advance.
  - Codes 6/7 are unreachable. If ever present, evaluate as NAND and advance to 0.
- Function: reduction over all N_IN operands. AND/OR/XOR = &a, |a, ^a (XOR is parity). NAND/NOR/XNOR are their inversions.
- result_q: registered every clk, computed from the current db states and current mode. A mode change and an operand change on the same cycle both take effect in the same result_q update.
- Latency, raw pin edge to led_n change: 2 (sync) + DEBOUNCE_CYCLES + 1 (result_q) clk cycles. The mode LEDs follow the same path plus one FSM cycle.
- LED map (active-low):
  - led_n[0] = ~result_q.
  - led_n[3:1] = ~mode.
  - led_n[4] = ~(any operand pressed).
  - led_n[LED_W-1:5] = 1 (off), unless the optional feature is enabled.
- Reset mid-press: all state returns to reset values immediately. A button still held after reset is re-accepted only after a full debounce interval, and does not count as a mode press edge unless db transitions 1→0 again after reset.

Optional Feature:
- Macro: GATE_LAB_HEARTBEAT_EN.
- Defined: led_n[5] toggles every 2^24 clk cycles (~0.62 s at 27 MHz) via a free-running 24-bit counter. The counter resets to 0 and led_n[5] resets to 1.
- Undefined: no counter is instantiated and led_n[5] = 1 constantly.

Decomposition:
- Package gate_lab_pkg holds:
  - mode enum typedef gate_mode_t (3 bits, values above),
  - MODE_LAST = 5,
  - HB_BITS = 24.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk, rst_n, raw_n, db_n, fall_pulse) owns the synchroniser, counter and 1-cycle press-edge pulse. It is instantiated N_IN+1 times.

Test Plan (DEBOUNCE_CYCLES=4, N_IN=2):
- Reset with both buttons held low → led_n = 6'b111111 and mode = 0 during reset. After release of rst_n and 7 cycles, led_n[0] = 1 (NAND(1,1) = 0, LED off).
- Mode NAND, btn_n = 2'b10 (a = 01) → led_n[0] = 0 exactly 7 cycles after the pin change; a 3-cycle glitch on btn_n[1] produces no change.
- Press mode button 6 times, each held 10 cycles and released 10 cycles → mode goes 1,2,3,4,5,0. Holding it pressed for 100 cycles advances only once.
- Mode XOR (4), a = 11 → led_n[0] = 1. a = 01 → led_n[0] = 0. led_n[3:1] = 3'b011.
- Assert rst_n low mid-debounce (cnt = 2) with mode = 3 → mode = 0 and led_n = all 1s immediately. Post-reset, the held button needs a full 4-cycle interval.
- With GATE_LAB_HEARTBEAT_EN defined → led_n[5] first toggles at cycle 2^24 after reset. Undefined → led_n[5] stays 1.
